// File: rtl/hint_sched_pkg.sv
// Shared types for hint_scheduler: FSM encoding, hint record and the unused-slot value.
// Optional ordering checks are enabled by defining HINT_SCHED_CHECK_EN.
package hint_sched_pkg;

    localparam int unsigned HINT_AW = 32;
    localparam int unsigned HINT_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_ERR     = 2'd3
    } state_e;

    typedef struct packed {
        logic               is_write;
        logic [HINT_AW-1:0] address;
        logic [HINT_DW-1:0] data;
    } hint_t;

    localparam int unsigned HINT_W = $bits(hint_t);

    // Unused slots look like writes so a read-matching decoder never hits them.
    localparam hint_t HINT_UNUSED = '{is_write: 1'b1, address: '0, data: '0};

    // A request for three hints is served as two.
    function automatic logic [1:0] clamp_need(input logic [1:0] need);
        return (need == 2'd3) ? 2'd2 : need;
    endfunction

endpackage

// File: rtl/hint_fifo.sv
// Circular hint buffer: single push, pop of 0-2 entries, head and head+1 read ports.
module hint_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic [1:0]               pop_cnt,
    output logic [W-1:0]             head_c,
    output logic [W-1:0]             head1_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
        count_d  = count_q + CW'(push) - CW'(pop_cnt);
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_c      = mem_q[rd_ptr_q];
    assign head1_c     = mem_q[rd_ptr_q + PW'(1)];
    assign count       = count_q;
    assign count_nxt_c = count_d;

endmodule

// File: rtl/hint_scheduler.sv
// Hands each instruction step exactly the hints it needs, via request/present/retire.
// Define HINT_SCHED_CHECK_EN to add the sticky ordering/request error state.
module hint_scheduler
    import hint_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_is_write,
    input  logic [AW-1:0]          in_address,
    input  logic [DW-1:0]          in_data,
    input  logic                   step_valid,
    input  logic [1:0]             step_need,
    output logic                   step_ready,
    output logic                   hints_valid,
    output logic                   step_done,
    output logic                   hint1_is_write,
    output logic [AW-1:0]          hint1_address,
    output logic [DW-1:0]          hint1_data,
    output logic                   hint2_is_write,
    output logic [AW-1:0]          hint2_address,
    output logic [DW-1:0]          hint2_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   hint_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    if (AW != HINT_AW || DW != HINT_DW) begin : g_bad_width
        $error("hint_scheduler: AW/DW must match the hint_sched_pkg record widths");
    end

    state_e        state_q, state_d;
    logic [1:0]    need_q, need_d;
    hint_t         hint1_q, hint1_d;
    hint_t         hint2_q, hint2_d;
    logic          hints_valid_q, hints_valid_d;
    logic          step_ready_q, step_ready_d;
    logic          in_ready_q, in_ready_d;
    logic          present_d;
    logic [1:0]    pop_cnt;
    logic          push;
    hint_t         wdata, head, head1, slot1, slot2;
    logic [CW-1:0] count, count_nxt;

`ifdef HINT_SCHED_CHECK_EN
    logic need3_q, need3_d;
    logic err_q, err_d;
    logic order_bad;
`endif

    assign push  = in_valid & in_ready_q;
    assign wdata = '{is_write: in_is_write, address: in_address, data: in_data};

    hint_fifo #(
        .DEPTH (DEPTH),
        .W     (HINT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .wdata       (wdata),
        .pop_cnt     (pop_cnt),
        .head_c      (head),
        .head1_c     (head1),
        .count       (count),
        .count_nxt_c (count_nxt)
    );

    // Slot candidates for the current request; unused slots are write/zero.
    always_comb begin
        slot1 = HINT_UNUSED;
        slot2 = HINT_UNUSED;
        if (need_q != 2'd0) begin
            slot1 = head;
        end
        if (need_q == 2'd2) begin
            slot2 = head1;
        end
    end

`ifdef HINT_SCHED_CHECK_EN
    assign order_bad = (need_q == 2'd2) && head.is_write && !head1.is_write;
`endif

    always_comb begin
        state_d   = state_q;
        need_d    = need_q;
        hint1_d   = hint1_q;
        hint2_d   = hint2_q;
        pop_cnt   = 2'd0;
        present_d = 1'b0;
`ifdef HINT_SCHED_CHECK_EN
        need3_d   = need3_q;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (step_valid) begin
                    need_d  = clamp_need(step_need);
                    state_d = ST_WAIT;
`ifdef HINT_SCHED_CHECK_EN
                    need3_d = (step_need == 2'd3);
`endif
                end
            end
            ST_WAIT: begin
                if (count >= CW'(need_q)) begin
`ifdef HINT_SCHED_CHECK_EN
                    if (need3_q || order_bad) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
`else
                    begin
`endif
                        hint1_d   = slot1;
                        hint2_d   = slot2;
                        present_d = 1'b1;
                        state_d   = ST_PRESENT;
                    end
                end
            end
            ST_PRESENT: begin
                pop_cnt = need_q;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
`ifndef HINT_SCHED_CHECK_EN
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        hints_valid_d = present_d;
        step_ready_d  = (state_d == ST_IDLE);
        in_ready_d    = (count_nxt < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            need_q        <= 2'd0;
            hint1_q       <= HINT_UNUSED;
            hint2_q       <= HINT_UNUSED;
            hints_valid_q <= 1'b0;
            step_ready_q  <= 1'b1;
            in_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            need_q        <= need_d;
            hint1_q       <= hint1_d;
            hint2_q       <= hint2_d;
            hints_valid_q <= hints_valid_d;
            step_ready_q  <= step_ready_d;
            in_ready_q    <= in_ready_d;
        end
    end

`ifdef HINT_SCHED_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            need3_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            need3_q <= need3_d;
            err_q   <= err_d;
        end
    end
    assign hint_err = err_q;
`else
    assign hint_err = 1'b0;
`endif

    assign in_ready       = in_ready_q;
    assign step_ready     = step_ready_q;
    assign hints_valid    = hints_valid_q;
    assign step_done      = hints_valid_q;
    assign hint1_is_write = hint1_q.is_write;
    assign hint1_address  = hint1_q.address;
    assign hint1_data     = hint1_q.data;
    assign hint2_is_write = hint2_q.is_write;
    assign hint2_address  = hint2_q.address;
    assign hint2_data     = hint2_q.data;
    assign fifo_count     = count;

endmodule
